// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF response generator.
// Measures NUM_PAIRS oscillator pairs in turn with one shared counter pair over
// a programmable clk-cycle window, and builds a response word plus a per-bit
// instability mask for the key/ID logic.
`timescale 1ns/1ps

module ro_puf_array #(
  parameter int unsigned NUM_PAIRS = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WIN_W     = 16,
  parameter int unsigned MARGIN    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_PAIRS-1:0] ro_in,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  output logic                   busy,
  output logic                   done,
  output logic                   resp_valid,
  output logic [NUM_PAIRS-1:0]   response,
  output logic [NUM_PAIRS-1:0]   unstable,
  output logic                   sat
);

  localparam int unsigned   IDX_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned   RO_W     = 2 * NUM_PAIRS;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state;

  // Oscillator sampling chain: two metastability flops, then a history flop.
  logic [RO_W-1:0] sync1;
  logic [RO_W-1:0] sync2;
  logic [RO_W-1:0] hist;

  // Run bookkeeping.
  logic [IDX_W-1:0] idx;
  logic [WIN_W-1:0] win_lat;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Selected-pair edge detection.
  logic sel_a;
  logic sel_b;
  logic hist_a;
  logic hist_b;
  logic rise_a;
  logic rise_b;

  // Pair comparison.
  logic             a_gt_b;
  logic [CNT_W:0]   diff;
  logic             close;

  // Synchronize every oscillator bit and keep one cycle of history. The
  // history flops follow the synchronized value every cycle, so when CLEAR
  // switches to a new pair its history already equals its current sync value
  // and no spurious edge appears at the start of MEASURE.
  // NOTE: every flop here, synchronizers included, gets an explicit async
  // reset value so a reset leaves no stale oscillator history behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Route the selected pair's synchronized bits to the shared edge detectors.
  // NOTE: every output of this block gets a default first, so no path through
  // the loop leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    hist_a = 1'b0;
    hist_b = 1'b0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_a  = sync2[2*k];
        sel_b  = sync2[2*k+1];
        hist_a = hist[2*k];
        hist_b = hist[2*k+1];
      end
    end
    rise_a = (state == S_MEASURE) && sel_a && !hist_a;
    rise_b = (state == S_MEASURE) && sel_b && !hist_b;
  end

  // Magnitude comparison on CNT_W+1 bits so the difference never wraps.
  always_comb begin
    a_gt_b = (cnt_a > cnt_b);
    if (a_gt_b) begin
      diff = {1'b0, cnt_a} - {1'b0, cnt_b};
    end else begin
      diff = {1'b0, cnt_b} - {1'b0, cnt_a};
    end
    close = (64'(diff) < 64'(MARGIN));
  end

  // Sequencer: clear, measure and compare each pair, then report.
  // NOTE: state and outputs are updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      win_lat    <= '0;
      win_cnt    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= '0;
      unstable   <= '0;
      sat        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // A zero-length window would never end; treat it as one cycle.
            win_lat    <= (win_len == '0) ? WIN_ONE : win_len;
            idx        <= '0;
            resp_valid <= 1'b0;
            response   <= '0;
            unstable   <= '0;
            sat        <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          cnt_a   <= '0;
          cnt_b   <= '0;
          win_cnt <= win_lat;
          state   <= S_MEASURE;
        end

        S_MEASURE: begin
          // Saturating counts; any increment refused at full scale is flagged.
          if (rise_a) begin
            if (cnt_a == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              cnt_a <= cnt_a + 1'b1;
            end
          end
          if (rise_b) begin
            if (cnt_b == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              cnt_b <= cnt_b + 1'b1;
            end
          end
          win_cnt <= win_cnt - 1'b1;
          if (win_cnt == WIN_ONE) begin
            state <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          for (int k = 0; k < NUM_PAIRS; k++) begin
            if (idx == IDX_W'(k)) begin
              response[k] <= a_gt_b;
              unstable[k] <= close;
            end
          end
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_CLEAR;
          end
        end

        S_DONE: begin
          done       <= 1'b1;
          resp_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_array.sv
// Bench for ro_puf_array: two instances (wide and narrow counters) share one
// set of clk-synchronous oscillator waveforms. A model records the waveform,
// derives edge counts per measurement window, and predicts every output.
`timescale 1ns/1ps

module tb_ro_puf_array;

  localparam int NP   = 2;
  localparam int RW   = 2 * NP;
  localparam int WW   = 16;
  localparam int MG   = 4;
  localparam int CW_D = 16;
  localparam int CW_S = 4;
  localparam int REC  = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] win_len = '0;
  logic [RW-1:0] ro_in = '0;

  logic          d_busy, d_done, d_rv, d_sat;
  logic [NP-1:0] d_resp, d_unst;
  logic          s_busy, s_done, s_rv, s_sat;
  logic [NP-1:0] s_resp, s_unst;

  ro_puf_array #(.NUM_PAIRS(NP), .CNT_W(CW_D), .WIN_W(WW), .MARGIN(MG)) u_dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .win_len(win_len),
    .busy(d_busy), .done(d_done), .resp_valid(d_rv), .response(d_resp),
    .unstable(d_unst), .sat(d_sat)
  );

  ro_puf_array #(.NUM_PAIRS(NP), .CNT_W(CW_S), .WIN_W(WW), .MARGIN(MG)) u_sat (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .win_len(win_len),
    .busy(s_busy), .done(s_done), .resp_valid(s_rv), .response(s_resp),
    .unstable(s_unst), .sat(s_sat)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- oscillator stimulus: per-bit period, 50% duty ----------
  int per [RW];
  int cyc = 0;

  always @(negedge clk) begin
    for (int i = 0; i < RW; i++) begin
      if (per[i] > 0) ro_in[i] = ((cyc % per[i]) < (per[i] / 2));
      else            ro_in[i] = 1'b0;
    end
    cyc++;
  end

  task automatic set_per(input int p0, input int p1, input int p2, input int p3);
    per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- behavioural model -------------------------------------
  logic [RW-1:0] v_rec [REC];
  int            edge_n = 0;
  bit            m_active = 1'b0;
  int            m_s, m_w, m_done_edge;
  logic          m_busy = 1'b0, m_done = 1'b0, m_rv = 1'b0;
  logic [NP-1:0] m_resp_d = '0, m_unst_d = '0, m_resp_s = '0, m_unst_s = '0;
  logic          m_sat_d = 1'b0, m_sat_s = 1'b0;

  // Rising transitions of one oscillator bit over w consecutive clk samples.
  function automatic int count_rises(input int first, input int w, input int b);
    int c = 0;
    for (int m = first; m < first + w; m++) begin
      if (m >= 1 && m < REC && v_rec[m][b] && !v_rec[m-1][b]) c++;
    end
    return c;
  endfunction

  // Apply a counter width: saturation, comparison and margin rule.
  function automatic void score(input int ta, input int tb, input int cw,
                                output bit r, output bit u, output bit s);
    int mx = (1 << cw) - 1;
    int a  = (ta > mx) ? mx : ta;
    int b  = (tb > mx) ? mx : tb;
    s = (ta > mx) || (tb > mx);
    r = (a > b);
    u = (((a > b) ? (a - b) : (b - a)) < MG);
  endfunction

  task automatic model_results();
    bit r, u, s;
    m_sat_d = 1'b0;
    m_sat_s = 1'b0;
    for (int p = 0; p < NP; p++) begin
      int ta = count_rises(m_s + p * (m_w + 2), m_w, 2*p);
      int tb = count_rises(m_s + p * (m_w + 2), m_w, 2*p + 1);
      score(ta, tb, CW_D, r, u, s);
      m_resp_d[p] = r; m_unst_d[p] = u; m_sat_d = m_sat_d | s;
      score(ta, tb, CW_S, r, u, s);
      m_resp_s[p] = r; m_unst_s[p] = u; m_sat_s = m_sat_s | s;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_rv = 1'b0;
      m_resp_d = '0; m_unst_d = '0; m_resp_s = '0; m_unst_s = '0;
      m_sat_d = 1'b0; m_sat_s = 1'b0;
    end else begin
      if (edge_n < REC) v_rec[edge_n] = ro_in;
      m_done = 1'b0;
      if (m_active && edge_n == m_done_edge) begin
        model_results();
        m_busy = 1'b0; m_done = 1'b1; m_rv = 1'b1; m_active = 1'b0;
      end else if (!m_busy && start) begin
        m_s = edge_n;
        m_w = (win_len == '0) ? 1 : int'(win_len);
        m_done_edge = edge_n + NP * (m_w + 2) + 1;
        m_active = 1'b1;
        m_busy = 1'b1; m_rv = 1'b0;
        m_resp_d = '0; m_unst_d = '0; m_resp_s = '0; m_unst_s = '0;
        m_sat_d = 1'b0; m_sat_s = 1'b0;
      end
      edge_n++;
    end
  end

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy",       32'(d_busy), 32'(m_busy));
      check("done",       32'(d_done), 32'(m_done));
      check("resp_valid", 32'(d_rv),   32'(m_rv));
      check("n_busy",     32'(s_busy), 32'(m_busy));
      check("n_done",     32'(s_done), 32'(m_done));
      check("n_resp_valid", 32'(s_rv), 32'(m_rv));
      if (!m_busy) begin
        check("response",   32'(d_resp), 32'(m_resp_d));
        check("unstable",   32'(d_unst), 32'(m_unst_d));
        check("sat",        32'(d_sat),  32'(m_sat_d));
        check("n_response", 32'(s_resp), 32'(m_resp_s));
        check("n_unstable", 32'(s_unst), 32'(m_unst_s));
        check("n_sat",      32'(s_sat),  32'(m_sat_s));
      end
    end
  end

  // ---------------- run helper ---------------------------------------------
  // Issues start, optionally a second start extra_at cycles later, and returns
  // the number of clk edges from the start-sampling edge to done.
  task automatic run(input int w, input int extra_at, output int lat);
    int n = 0;
    int busy_low = 0;
    int rv_early = 0;
    bit seen = 1'b0;
    @(negedge clk);
    win_len = 16'(w);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    while (!seen && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == extra_at);
      if (d_done) seen = 1'b1;
      else begin
        if (!d_busy) busy_low++;
        if (d_rv)    rv_early++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("busy_held", 32'(busy_low), 32'd0);
    check("rv_before_done", 32'(rv_early), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(d_done), 32'd0);
    lat = n;
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    int lat;
    int pulses;
    for (int i = 0; i < RW; i++) per[i] = 0;

    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset state and idle without start.
    check("rst_busy", 32'(d_busy), 32'd0);
    check("rst_resp", 32'(d_resp), 32'd0);
    repeat (50) @(negedge clk);
    check("idle_busy", 32'(d_busy), 32'd0);
    check("idle_done", 32'(d_done), 32'd0);
    check("idle_rv",   32'(d_rv),   32'd0);

    // Main function: A faster on pair 0, B faster on pair 1.
    set_per(4, 10, 10, 4);
    run(100, 0, lat);
    check("t1_latency",  32'(lat),    32'd205);
    check("t1_response", 32'(d_resp), 32'b01);
    check("t1_unstable", 32'(d_unst), 32'b00);
    check("t1_sat",      32'(d_sat),  32'd0);
    check("t1_rv",       32'(d_rv),   32'd1);

    // Tie on pair 0 (flagged unstable); pair 1 differs by exactly MARGIN.
    set_per(8, 8, 8, 16);
    run(64, 0, lat);
    check("tie_latency",  32'(lat),       32'd133);
    check("tie_resp0",    32'(d_resp[0]), 32'd0);
    check("tie_unst0",    32'(d_unst[0]), 32'd1);
    check("tie_response", 32'(d_resp),    32'b10);
    check("tie_unstable", 32'(d_unst),    32'b01);

    // Saturation on the 4-bit instance: both pair-0 counters clip at 15.
    set_per(2, 6, 10, 20);
    run(100, 0, lat);
    check("sat_flag",     32'(s_sat),  32'd1);
    check("sat_response", 32'(s_resp), 32'b10);
    check("sat_unstable", 32'(s_unst), 32'b01);
    check("wide_sat",     32'(d_sat),  32'd0);
    check("wide_resp",    32'(d_resp), 32'b11);

    // Zero window behaves as one cycle; a second start mid-run is dropped.
    set_per(0, 0, 0, 0);
    run(0, 2, lat);
    check("win0_latency",  32'(lat),    32'd7);
    check("win0_response", 32'(d_resp), 32'b00);
    check("win0_unstable", 32'(d_unst), 32'b11);
    repeat (20) @(negedge clk);
    check("win0_no_rerun", 32'(d_busy), 32'd0);

    // Reset during pair 1 measurement aborts the run with no done pulse.
    set_per(4, 10, 10, 4);
    @(negedge clk);
    win_len = 16'd100;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (150) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(d_busy), 32'd0);
    check("abort_done", 32'(d_done), 32'd0);
    check("abort_rv",   32'(d_rv),   32'd0);
    check("abort_resp", 32'(d_resp), 32'd0);
    check("abort_unst", 32'(d_unst), 32'd0);
    check("abort_sat",  32'(s_sat),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (d_done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    // Fresh run after the abort completes normally.
    run(100, 0, lat);
    check("fresh_latency",  32'(lat),    32'd205);
    check("fresh_response", 32'(d_resp), 32'b01);
    check("fresh_unstable", 32'(d_unst), 32'b00);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
